// File: rtl/glb_axil_pkg.sv
// Shared constants and FSM state type for the AXI4-Lite to GLB config register bridge.
package glb_axil_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RD_TIMEOUT = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_PRE,
        WR_ACC,
        WR_RESP,
        RD_PRE,
        RD_ACC,
        RD_WAIT,
        RD_RESP
    } state_t;

    // Register accesses are whole 32-bit words only.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/glb_axil_reg_bridge.sv
// AXI4-Lite slave driving the GLB single-beat config register port, one access at a time.
// Optional macro GLB_AXIL_RD_TIMEOUT_EN adds an RD_TIMEOUT-cycle read watchdog answering SLVERR.
module glb_axil_reg_bridge
    import glb_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic                    wr_en,
    output logic                    wr_clk_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    rd_en,
    output logic                    rd_clk_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_data_valid
);

    if (DATA_WIDTH != 32 || RD_TIMEOUT < 1) begin : g_bad_params
        $error("glb_axil_reg_bridge: DATA_WIDTH must be 32 and RD_TIMEOUT must be positive");
    end

    state_t state;
    logic   last_wr;
    logic   wr_pend;
    logic   rd_pend;
    logic   accept_wr;
    logic   accept_rd;

`ifdef GLB_AXIL_RD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(RD_TIMEOUT);
    logic [CNT_W-1:0] rd_cnt;
`endif

    // AW and W are only taken as a pair; on contention the side not served last wins.
    always_comb begin
        wr_pend   = s_awvalid && s_wvalid;
        rd_pend   = s_arvalid;
        accept_wr = 1'b0;
        accept_rd = 1'b0;
        if (!reset && state == IDLE) begin
            accept_wr = wr_pend && (!rd_pend || !last_wr);
            accept_rd = rd_pend && (!wr_pend || last_wr);
        end
    end

    assign s_awready = accept_wr;
    assign s_wready  = accept_wr;
    assign s_arready = accept_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_wr   <= 1'b0;
            s_bresp   <= RESP_OKAY;
            s_bvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
            s_rvalid  <= 1'b0;
            wr_en     <= 1'b0;
            wr_clk_en <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_en     <= 1'b0;
            rd_clk_en <= 1'b0;
            rd_addr   <= '0;
`ifdef GLB_AXIL_RD_TIMEOUT_EN
            rd_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept_wr) begin
                        last_wr <= 1'b1;
                        wr_addr <= s_awaddr;
                        wr_data <= s_wdata;
                        if (misaligned(s_awaddr[1:0]) || !(&s_wstrb)) begin
                            s_bvalid <= 1'b1;
                            s_bresp  <= RESP_SLVERR;
                            state    <= WR_RESP;
                        end else begin
                            wr_clk_en <= 1'b1;
                            state     <= WR_PRE;
                        end
                    end else if (accept_rd) begin
                        last_wr <= 1'b0;
                        rd_addr <= s_araddr;
                        if (misaligned(s_araddr[1:0])) begin
                            s_rvalid <= 1'b1;
                            s_rresp  <= RESP_SLVERR;
                            s_rdata  <= '0;
                            state    <= RD_RESP;
                        end else begin
                            rd_clk_en <= 1'b1;
                            state     <= RD_PRE;
                        end
                    end
                end
                WR_PRE: begin
                    wr_en <= 1'b1;
                    state <= WR_ACC;
                end
                WR_ACC: begin
                    wr_en     <= 1'b0;
                    wr_clk_en <= 1'b0;
                    s_bvalid  <= 1'b1;
                    s_bresp   <= RESP_OKAY;
                    state     <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RD_PRE: begin
                    rd_en <= 1'b1;
                    state <= RD_ACC;
`ifdef GLB_AXIL_RD_TIMEOUT_EN
                    rd_cnt <= '0;
`endif
                end
                RD_ACC: begin
                    rd_en <= 1'b0;
`ifdef GLB_AXIL_RD_TIMEOUT_EN
                    rd_cnt <= rd_cnt + CNT_W'(1);
`endif
                    if (rd_data_valid) begin
                        rd_clk_en <= 1'b0;
                        s_rdata   <= rd_data;
                        s_rresp   <= RESP_OKAY;
                        s_rvalid  <= 1'b1;
                        state     <= RD_RESP;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Data arriving in the expiry cycle takes priority over the timeout.
                    if (rd_data_valid) begin
                        rd_clk_en <= 1'b0;
                        s_rdata   <= rd_data;
                        s_rresp   <= RESP_OKAY;
                        s_rvalid  <= 1'b1;
                        state     <= RD_RESP;
                    end
`ifdef GLB_AXIL_RD_TIMEOUT_EN
                    else if (rd_cnt >= TIMEOUT_VAL) begin
                        rd_clk_en <= 1'b0;
                        s_rdata   <= '0;
                        s_rresp   <= RESP_SLVERR;
                        s_rvalid  <= 1'b1;
                        state     <= RD_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
`endif
                end
                RD_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glb_axil_reg_bridge.sv
// Directed bench for glb_axil_reg_bridge: vector table plus arbitration, reset and read-timeout sequences.
// Build with or without GLB_AXIL_RD_TIMEOUT_EN; the timeout sequence adapts to the macro.
module tb_glb_axil_reg_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        wr_en;
    logic        wr_clk_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic        rd_clk_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_data_valid;

    glb_axil_reg_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RD_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_awaddr(s_awaddr),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_wdata(s_wdata),
        .s_wstrb(s_wstrb),
        .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bresp(s_bresp),
        .s_bvalid(s_bvalid),
        .s_bready(s_bready),
        .s_araddr(s_araddr),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata(s_rdata),
        .s_rresp(s_rresp),
        .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .wr_en(wr_en),
        .wr_clk_en(wr_clk_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_clk_en(rd_clk_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Observation at the falling edge: per-cycle strobe logs, totals and handshake records.
    logic        wr_ce_log [4096];
    logic        wr_en_log [4096];
    logic        rd_en_log [4096];
    int          wr_en_total = 0;
    int          rd_en_total = 0;
    int          rd_ce_total = 0;
    int          b_hs_total = 0;
    int          r_hs_total = 0;
    int          rvalid_total = 0;
    int          overlap = 0;
    int          rd_en_cyc = -1;
    logic [31:0] wr_en_addr = '0;
    logic [31:0] wr_en_data = '0;
    logic [31:0] r_last_data = '0;
    bit          order_q [$];
    logic [31:0] regs [logic [31:0]];

    always @(negedge clk) begin
        wr_ce_log[cyc % 4096] = wr_clk_en;
        wr_en_log[cyc % 4096] = wr_en;
        rd_en_log[cyc % 4096] = rd_en;
        if (wr_en) begin
            wr_en_total++;
            wr_en_addr = wr_addr;
            wr_en_data = wr_data;
            regs[wr_addr] = wr_data;
        end
        if (rd_en) begin
            rd_en_total++;
            rd_en_cyc = cyc;
        end
        if (rd_clk_en) rd_ce_total++;
        if (wr_en && rd_en) overlap++;
        if (s_awvalid && s_awready) order_q.push_back(1'b1);
        if (s_arvalid && s_arready) order_q.push_back(1'b0);
        if (s_bvalid && s_bready) b_hs_total++;
        if (s_rvalid) rvalid_total++;
        if (s_rvalid && s_rready) begin
            r_hs_total++;
            r_last_data = s_rdata;
        end
    end

    // Register-side model: answers rd_en after rd_lat cycles (never when rd_lat < 0).
    int rd_lat = 0;
    int rd_tgt = -1;

    initial begin
        rd_data_valid = 1'b0;
        rd_data = 32'h0;
        forever begin
            @(negedge clk);
            if (rd_en && rd_lat >= 0) rd_tgt = cyc + rd_lat;
            if (rd_tgt == cyc) begin
                rd_data_valid = 1'b1;
                rd_data = regs.exists(rd_addr) ? regs[rd_addr] : 32'hDEAD_BEEF;
            end else begin
                rd_data_valid = 1'b0;
                rd_data = 32'h5555_AAAA;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_bits();
        return {15'd0, s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp,
                |s_rdata, wr_en, wr_clk_en, |wr_addr, |wr_data, rd_en, rd_clk_en, |rd_addr};
    endfunction

    // Results of the last do_txn call.
    bit          t_got;
    bit          t_hold_ok;
    bit          t_drop_ok;
    logic [1:0]  t_resp;
    logic [31:0] t_data;
    int          t_acc_cyc;
    int          t_vld_cyc;

    task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int rdy_dly, input int bound);
        bit acc;
        t_got = 1'b0;
        t_hold_ok = 1'b1;
        t_drop_ok = 1'b0;
        t_resp = 2'b11;
        t_data = 32'hFFFF_FFFF;
        t_acc_cyc = -1;
        t_vld_cyc = -1;
        if (is_wr) begin
            s_awaddr = addr;
            s_wdata = data;
            s_wstrb = strb;
            s_awvalid = 1'b1;
            s_wvalid = 1'b1;
        end else begin
            s_araddr = addr;
            s_arvalid = 1'b1;
        end
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            if (is_wr ? (s_awready && s_wready) : s_arready) begin
                acc = 1'b1;
                t_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        s_arvalid = 1'b0;
        if (!acc) return;
        for (int i = 0; i < bound && !t_got; i++) begin
            if (is_wr ? s_bvalid : s_rvalid) begin
                t_got = 1'b1;
                t_vld_cyc = cyc;
                t_resp = is_wr ? s_bresp : s_rresp;
                t_data = is_wr ? 32'h0 : s_rdata;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!t_got) return;
        for (int i = 0; i < rdy_dly; i++) begin
            @(posedge clk);
            #1;
            if (is_wr) begin
                if (!s_bvalid || s_bresp != t_resp) t_hold_ok = 1'b0;
            end else begin
                if (!s_rvalid || s_rresp != t_resp || s_rdata != t_data) t_hold_ok = 1'b0;
            end
        end
        if (is_wr) s_bready = 1'b1;
        else s_rready = 1'b1;
        @(posedge clk);
        #1;
        s_bready = 1'b0;
        s_rready = 1'b0;
        t_drop_ok = is_wr ? !s_bvalid : !s_rvalid;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lat;
        int          rdy_dly;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n;
        int wr0, rd0, rce0, b0, r0, rv0, ob;
        logic [3:0] pat;
        int wa, ra;

        vecs[0] = '{1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b00, 32'h0,         3, 1};
        vecs[1] = '{1'b1, 32'h14, 32'h1234_5678, 4'hF, 0, 1, 2'b00, 32'h0,         3, 1};
        vecs[2] = '{1'b0, 32'h14, 32'h0,         4'hF, 3, 5, 2'b00, 32'h1234_5678, 6, 1};
        vecs[3] = '{1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, 32'h0,         1, 0};
        vecs[4] = '{1'b1, 32'h18, 32'h0BAD_F00D, 4'h3, 0, 0, 2'b10, 32'h0,         1, 0};
        vecs[5] = '{1'b0, 32'h10, 32'h0,         4'hF, 0, 0, 2'b00, 32'hCAFE_F00D, 3, 1};
        vecs[6] = '{1'b0, 32'h12, 32'h0,         4'hF, 0, 1, 2'b10, 32'h0,         1, 0};
        vecs[7] = '{1'b1, 32'h18, 32'h0000_0001, 4'hF, 0, 0, 2'b00, 32'h0,         3, 1};
        vecs[8] = '{1'b0, 32'h18, 32'h0,         4'hF, 1, 2, 2'b00, 32'h0000_0001, 4, 1};
        vecs[9] = '{1'b1, 32'h13, 32'h7777_7777, 4'hF, 0, 0, 2'b10, 32'h0,         1, 0};

        reset = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", out_bits(), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            rd_lat = vecs[i].lat;
            wr0 = wr_en_total;
            rd0 = rd_en_total;
            rce0 = rd_ce_total;
            do_txn(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].rdy_dly, 30);
            n = t_acc_cyc;
            chk($sformatf("v%0d_got", i), 32'(t_got), 32'd1);
            chk($sformatf("v%0d_resp", i), 32'(t_resp), 32'(vecs[i].exp_resp));
            chk($sformatf("v%0d_lat", i), t_vld_cyc - n, vecs[i].exp_lat);
            if (vecs[i].is_wr) begin
                chk($sformatf("v%0d_wr_en_count", i), wr_en_total - wr0, vecs[i].exp_acc);
                if (vecs[i].exp_acc != 0) begin
                    chk($sformatf("v%0d_wr_strobes", i),
                        32'({wr_ce_log[(n + 1) % 4096], wr_ce_log[(n + 2) % 4096], wr_ce_log[(n + 3) % 4096],
                             wr_en_log[(n + 1) % 4096], wr_en_log[(n + 2) % 4096], wr_en_log[(n + 3) % 4096]}),
                        32'b110_010);
                    chk($sformatf("v%0d_wr_addr", i), wr_en_addr, vecs[i].addr);
                    chk($sformatf("v%0d_wr_data", i), wr_en_data, vecs[i].data);
                end
            end else begin
                chk($sformatf("v%0d_rdata", i), t_data, vecs[i].exp_rdata);
                chk($sformatf("v%0d_rd_en_count", i), rd_en_total - rd0, vecs[i].exp_acc);
                if (vecs[i].exp_acc != 0) begin
                    chk($sformatf("v%0d_rd_en_cycle", i), 32'(rd_en_log[(n + 2) % 4096]), 32'd1);
                    chk($sformatf("v%0d_rd_clk_en_cycles", i), rd_ce_total - rce0, vecs[i].lat + 2);
                end
            end
            if (vecs[i].rdy_dly > 0) chk($sformatf("v%0d_hold", i), 32'(t_hold_ok), 32'd1);
            chk($sformatf("v%0d_valid_drop", i), 32'(t_drop_ok), 32'd1);
        end

        // Contending write and read straight out of reset: write first, then alternate.
        pulse_reset();
        rd_lat = 1;
        s_bready = 1'b1;
        s_rready = 1'b1;
        ob = order_q.size();
        b0 = b_hs_total;
        r0 = r_hs_total;
        s_awaddr = 32'h20; s_wdata = 32'hA5A5_0001; s_wstrb = 4'hF;
        s_araddr = 32'h20;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        wa = 0;
        ra = 0;
        for (int i = 0; i < 100 && (wa < 2 || ra < 2); i++) begin
            #1;
            if (s_awvalid && s_awready) wa++;
            if (s_arvalid && s_arready) ra++;
            @(posedge clk);
            #1;
            if (wa >= 2) begin
                s_awvalid = 1'b0;
                s_wvalid = 1'b0;
            end
            if (ra >= 2) s_arvalid = 1'b0;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        s_bready = 1'b0;
        s_rready = 1'b0;
        pat = 4'b0000;
        for (int i = 0; i < 4; i++) if (ob + i < order_q.size()) pat[3 - i] = order_q[ob + i];
        chk("arb_accept_count", order_q.size() - ob, 4);
        chk("arb_order", 32'(pat), 32'b1010);
        chk("arb_b_handshakes", b_hs_total - b0, 2);
        chk("arb_r_handshakes", r_hs_total - r0, 2);
        chk("arb_read_data", r_last_data, 32'hA5A5_0001);

        // Reset while the read waits on a register that never answers.
        rd_lat = -1;
        rd0 = rd_en_total;
        s_araddr = 32'h10;
        s_arvalid = 1'b1;
        wa = 0;
        for (int i = 0; i < 20 && wa == 0; i++) begin
            #1;
            if (s_arready) wa = 1;
            @(posedge clk);
            #1;
        end
        s_arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_read_issued", rd_en_total - rd0, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_read_outputs", out_bits(), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rv0 = rvalid_total;
        s_rready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        s_rready = 1'b0;
        chk("rst_no_rvalid_after", rvalid_total - rv0, 0);
        rd_lat = 0;
        do_txn(1'b1, 32'h1C, 32'h0F0F_0F0F, 4'hF, 0, 30);
        chk("rst_followup_wr_resp", 32'(t_resp), 32'(2'b00));
        chk("rst_followup_wr_lat", t_vld_cyc - t_acc_cyc, 3);
        chk("rst_followup_wr_data", wr_en_data, 32'h0F0F_0F0F);

        // Register never answers a read.
        rd_lat = -1;
        rd0 = rd_en_total;
        rce0 = rd_ce_total;
        do_txn(1'b0, 32'h18, 32'h0, 4'hF, 0, 40);
`ifdef GLB_AXIL_RD_TIMEOUT_EN
        chk("timeout_got", 32'(t_got), 32'd1);
        chk("timeout_resp", 32'(t_resp), 32'(2'b10));
        chk("timeout_rdata", t_data, 32'h0);
        chk("timeout_latency_from_rd_en", t_vld_cyc - rd_en_cyc, 9);
        chk("timeout_rd_clk_en_cycles", rd_ce_total - rce0, 10);
`else
        chk("no_timeout_rvalid", 32'(t_got), 32'd0);
        chk("no_timeout_rd_en", rd_en_total - rd0, 1);
        chk("no_timeout_clk_en_held", 32'(rd_clk_en), 32'd1);
`endif
        pulse_reset();

        chk("no_wr_rd_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
